lsu_ctrl: RTL
=============

# lsu_ctrl

Load/store controller for the RV32I pipeline's MEM stage. It takes the EX/MEM register's memory request and drives a variable-latency, word-organised data memory over a req/ack handshake. It stalls the pipeline until the access completes and returns aligned, sign- or zero-extended load data to the MEM/WB register. It also flags misaligned accesses and memory timeouts.

## Interface
Parameters:
- DM_ADDRESS, 9 — byte address width.
- DATA_W, 32 — data width; fixed at 32 (4 byte lanes).
- ACK_TIMEOUT, 15 — maximum cycles in REQ before abort; must be ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- addr  in  DM_ADDRESS  byte address (ALU result).
- wr_data  in  DATA_W  store data, unshifted.
- funct3  in  3  access size and signedness.
- stall  out  1  holds PC, IF/ID, ID/EX and EX/MEM.
- rd_data  out  DATA_W  extended load result, registered.
- misalign  out  1  one-cycle pulse: misaligned access dropped.
- timeout  out  1  one-cycle pulse: access aborted, no ack received.
- m_req  out  1  memory request.
- m_we  out  1  write when 1.
- m_addr  out  DM_ADDRESS-2  word address (addr[DM_ADDRESS-1:2]).
- m_be  out  4  byte enables.
- m_wdata  out  DATA_W  lane-replicated store data.
- m_ack  in  1  memory completion; may arrive in the same cycle as m_req.
- m_rdata  in  DATA_W  read word, valid while m_ack=1.

## Operation
FSM states:
- **IDLE**
  - A request is present when mem_read|mem_write.
  - If the request is aligned: latch addr, funct3, we (= mem_write; write wins if both are set), byte enables and data; go to REQ. stall=1 combinationally in this cycle.
  - If misaligned (half with addr[0]=1; word with addr[1:0]≠0): misalign=1 for this cycle, no access, stall=0, stay in IDLE, rd_data←0.
- **REQ**
  - m_req=1, stall=1. m_addr, m_we, m_be and m_wdata come from latched values and are stable until the ack.
  - On m_ack: for a load, rd_data←extended lane of m_rdata; go to DONE.
  - The wait counter counts cycles in REQ. If it reaches ACK_TIMEOUT without an ack: timeout=1, rd_data←0, go to DONE.
- **DONE**
  - stall=0 for exactly one cycle; the pipeline advances on this edge; go to IDLE.
  - This state guarantees the same EX/MEM entry is never issued twice.

Size and lane rules:
- funct3 000 LB/SB: m_be = 1<<addr[1:0]; store data = {4{wr_data[7:0]}}.
- funct3 001 LH/SH: m_be = 3<<{addr[1],1'b0}; store data = {2{wr_data[15:0]}}.
- funct3 010 LW/SW: m_be = 4'hF.
- funct3 100 LBU and 101 LHU: zero-extend.
- Any other funct3 value is treated as a word access.
- Loads drive m_be=4'hF; the lane is selected internally.

Other rules:
- m_ack outside REQ is ignored.
- Both pulse outputs are 0 at all other times.

## Timing
- Reset (reset=0, asynchronous):
  - State→IDLE; wait counter→0.
  - stall=0, m_req=0, m_we=0, m_addr=0, m_be=0, m_wdata=0, rd_data=0, misalign=0, timeout=0.
  - Reset in REQ drops m_req immediately; the memory must tolerate an abandoned request.
- Latency:
  - IDLE → REQ → DONE = 3 cycles with same-cycle ack; stall is high for 2 of them.
  - Each memory wait cycle adds 1.
  - Timeout path: stall is high for ACK_TIMEOUT+1 cycles.
- rd_data is valid in DONE and holds until the next completed load, misalign or reset.
- No overlap: at most one outstanding request.

## Structure
- Shared package (alongside the pipeline-register package):
  - lsu_state_t enum {IDLE, REQ, DONE}.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- Sub-module lsu_lane, purely combinational:
  - Computes m_be, m_wdata and misalignment from (addr[1:0], funct3, wr_data).
  - Computes load extraction and extension from (addr[1:0], funct3, m_rdata).
- lsu_ctrl holds the FSM, latches, wait counter and output registers.

## Test plan
- **SB, zero-wait memory.** SB addr=0x0D, wr_data=0x123456AB, ack in the same cycle → m_addr=0x03, m_be=4'b0010, m_wdata=0xABABABAB, m_we=1; stall high 2 cycles; DONE on cycle 3.
- **Signed and unsigned halfword loads.** LH addr=0x06, memory returns 0x8001_7FFF after 3 wait cycles → rd_data=0xFFFF8001, stall high 5 cycles. LHU at the same address → 0x00008001.
- **Misaligned word load.** LW addr=0x05 → misalign pulse 1 cycle, m_req never asserted, stall=0, rd_data=0.
- **Timeout.** SW with m_ack held 0, ACK_TIMEOUT=15 → timeout pulses once, DONE, stall falls; a late m_ack in IDLE is ignored.
- **Reset mid-access.** Assert reset while in REQ → m_req and stall drop without waiting for a clock edge. Next LW addr=0x00, returning 0xDEADBEEF → rd_data=0xDEADBEEF.
- **Back-to-back loads.** LB addr=0x03 then LBU addr=0x03 on data 0x80000000 → 0xFFFFFF80 then 0x00000080, each issued exactly once.

Source files
------------

// File: rtl/lsu_ctrl_pkg.sv
// ============================================================================
// Module   : lsu_ctrl_pkg
// Purpose  : Shared types and constants for the MEM-stage load/store unit:
//            FSM state encoding, RV32I load/store funct3 codes and a helper
//            that classifies funct3 into an access size.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unknown funct3 encodings fall back to a full word access.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    lsu_size_t sz;
    case (f3)
      F3_B, F3_BU: sz = SZ_B;
      F3_H, F3_HU: sz = SZ_H;
      F3_W:        sz = SZ_W;
      default:     sz = SZ_W;
    endcase
    return sz;
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage : lsu_ctrl_pkg

`default_nettype wire

// File: rtl/lsu_lane.sv
// ============================================================================
// Module   : lsu_lane
// Purpose  : Purely combinational byte-lane logic for the load/store unit.
//            Request side: byte enables, lane-replicated store data and the
//            misalignment check for the incoming request.
//            Load side: lane extraction and sign/zero extension of the read
//            word using the latched offset and funct3.
// Ports    : req_off/req_funct3/req_we/wr_data -> be, wdata, misalign
//            ld_off/ld_funct3/rdata            -> ld_data
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane
  import lsu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        req_off,
  input  logic [2:0]        req_funct3,
  input  logic              req_we,
  input  logic [DATA_W-1:0] wr_data,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata,
  output logic              misalign,
  input  logic [1:0]        ld_off,
  input  logic [2:0]        ld_funct3,
  input  logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ld_data
);

  lsu_size_t         w_req_sz;
  lsu_size_t         w_ld_sz;
  logic [3:0]        w_st_be;
  logic [DATA_W-1:0] w_shifted;
  logic              w_sext;

  // Request side
  always_comb begin
    w_req_sz = f3_size(req_funct3);
    w_st_be  = 4'hF;
    wdata    = wr_data;
    misalign = 1'b0;
    case (w_req_sz)
      SZ_B: begin
        w_st_be = 4'b0001 << req_off;
        wdata   = {4{wr_data[7:0]}};
      end
      SZ_H: begin
        w_st_be  = 4'b0011 << {req_off[1], 1'b0};
        wdata    = {2{wr_data[15:0]}};
        misalign = req_off[0];
      end
      default: begin
        w_st_be  = 4'hF;
        misalign = |req_off;
      end
    endcase
    // Loads always fetch the whole word; the lane is picked on return.
    be = req_we ? w_st_be : 4'hF;
  end

  // Load side: only aligned accesses reach memory, so shifting by the full
  // byte offset lands the addressed byte/half in the low bits.
  always_comb begin
    w_ld_sz   = f3_size(ld_funct3);
    w_sext    = ~f3_unsigned(ld_funct3);
    w_shifted = rdata >> {ld_off, 3'b000};
    case (w_ld_sz)
      SZ_B:    ld_data = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    ld_data = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: ld_data = rdata;
    endcase
  end

endmodule : lsu_lane

`default_nettype wire

// File: rtl/lsu_ctrl.sv
// ============================================================================
// Module   : lsu_ctrl
// Purpose  : MEM-stage load/store controller. Issues one word-organised
//            req/ack memory access per EX/MEM entry, stalls the pipeline until
//            it completes, returns extended load data, and flags misaligned
//            accesses and ack timeouts.
// Ports    : clk, reset (async, active-low)
//            mem_read, mem_write, addr, wr_data, funct3  - request from EX/MEM
//            stall, rd_data, misalign, timeout           - to pipeline/MEM/WB
//            m_req, m_we, m_addr, m_be, m_wdata          - to data memory
//            m_ack, m_rdata                              - from data memory
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int DM_ADDRESS  = 9,
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [2:0]            funct3,
  output logic                  stall,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  misalign,
  output logic                  timeout,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DM_ADDRESS-3:0] m_addr,
  output logic [3:0]            m_be,
  output logic [DATA_W-1:0]     m_wdata,
  input  logic                  m_ack,
  input  logic [DATA_W-1:0]     m_rdata
);

  localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  lsu_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DM_ADDRESS-1:0] addr_q, addr_d;
  logic [2:0]            f3_q, f3_d;
  logic                  we_q, we_d;
  logic [3:0]            be_q, be_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rd_data_q, rd_data_d;

  logic [3:0]            w_lane_be;
  logic [DATA_W-1:0]     w_lane_wdata;
  logic                  w_lane_misalign;
  logic [DATA_W-1:0]     w_ld_data;
  logic                  w_stall;
  logic                  w_misalign;

  lsu_lane #(
    .DATA_W (DATA_W)
  ) u_lane (
    .req_off    (addr[1:0]),
    .req_funct3 (funct3),
    .req_we     (mem_write),
    .wr_data    (wr_data),
    .be         (w_lane_be),
    .wdata      (w_lane_wdata),
    .misalign   (w_lane_misalign),
    .ld_off     (addr_q[1:0]),
    .ld_funct3  (f3_q),
    .rdata      (m_rdata),
    .ld_data    (w_ld_data)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    f3_d       = f3_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rd_data_d  = rd_data_q;
    w_stall    = 1'b0;
    w_misalign = 1'b0;
    timeout    = 1'b0;
    m_req      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          if (w_lane_misalign) begin
            // Dropped without touching memory; the pipeline moves on.
            w_misalign = 1'b1;
            rd_data_d  = '0;
          end else begin
            w_stall = 1'b1;
            addr_d  = addr;
            f3_d    = funct3;
            we_d    = mem_write;
            be_d    = w_lane_be;
            wdata_d = w_lane_wdata;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end

      REQ: begin
        m_req   = 1'b1;
        w_stall = 1'b1;
        if (m_ack) begin
          if (!we_q) begin
            rd_data_d = w_ld_data;
          end
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          timeout   = 1'b1;
          rd_data_d = '0;
          cnt_d     = '0;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // One non-stalled cycle so the pipeline retires this EX/MEM entry
      // before the next one can be sampled in IDLE.
      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The IDLE-state stall/misalign terms depend on live inputs, so they are
  // gated while reset is held to keep both low during reset.
  assign stall    = w_stall & reset;
  assign misalign = w_misalign & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      f3_q      <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      f3_q      <= f3_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign m_we    = we_q;
  assign m_addr  = addr_q[DM_ADDRESS-1:2];
  assign m_be    = be_q;
  assign m_wdata = wdata_q;
  assign rd_data = rd_data_q;

endmodule : lsu_ctrl

`default_nettype wire
